// File: rtl/stack_pkg.sv
// stack_pkg: shared encodings for the stack-machine multicycle controller
package stack_pkg;
  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_NOT = 4'h3;
  localparam logic [3:0] OP_PUSH = 4'h4, OP_POP = 4'h5, OP_JMP = 4'h6, OP_JZ = 4'h7;
  localparam logic [3:0] OP_OR = 4'h8, OP_DUP = 4'h9, OP_JNZ = 4'hA, OP_NOP = 4'hB, OP_HALT = 4'hF;
  localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010, ALU_NOT = 3'b011, ALU_OR = 3'b100;
  localparam logic [1:0] SRC_MEM = 2'd0, SRC_ALU = 2'd1, SRC_B = 2'd2;
  typedef enum logic [1:0] {ERR_NONE, ERR_UNDER, ERR_OVER, ERR_ILLEGAL} err_t;
  typedef enum logic [4:0] {
    S_FETCH, S_DECODE, S_ALU_1, S_ALU_2, S_ALU_3, S_PUSH_RD, S_PUSH_WR, S_POP_1, S_POP_WR,
    S_JMP, S_JZ_1, S_BR_TAKE, S_DUP_1, S_DUP_2, S_DUP_3, S_HALT, S_ERROR
  } state_t;
  function automatic logic [2:0] alu_of(input logic [3:0] op);
    return op == OP_SUB ? ALU_SUB : op == OP_AND ? ALU_AND : op == OP_NOT ? ALU_NOT :
           op == OP_OR ? ALU_OR : ALU_ADD;
  endfunction
  function automatic logic [1:0] need_of(input logic [3:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR} ? 2'd2 :
           op inside {OP_NOT, OP_POP, OP_JZ, OP_JNZ, OP_DUP} ? 2'd1 : 2'd0;
  endfunction
endpackage

// File: rtl/stack_depth_tracker.sv
// stack_depth_tracker: stack occupancy counter with underflow/overflow checks
module stack_depth_tracker #(
  parameter int STACK_DEPTH = 16,
  parameter int DEPTH_W = $clog2(STACK_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [1:0]         need,
  input  logic               grow,
  output logic [DEPTH_W-1:0] depth,
  output logic               under,
  output logic               over
);
  localparam logic [DEPTH_W-1:0] FULL = DEPTH_W'(STACK_DEPTH);
  assign under = depth < DEPTH_W'(need);
  assign over = grow && depth >= FULL;
  always_ff @(posedge clk)
    if (rst) depth <= '0;
    else if (push && !pop && depth != FULL) depth <= depth + 1'b1;
    else if (pop && !push && depth != '0) depth <= depth - 1'b1;
endmodule

// File: rtl/stack_mc_controller.sv
// stack_mc_controller: multicycle control FSM for the stack-machine core with traps and halt
module stack_mc_controller import stack_pkg::*; #(
  parameter int INST_W = 12,
  parameter int STACK_DEPTH = 16,
  parameter int DEPTH_W = $clog2(STACK_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INST_W-1:0]  inst,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_write,
  output logic               mem_adr_src,
  output logic               ld_ir,
  output logic               ld_pc,
  output logic               pc_src,
  output logic [1:0]         stack_src,
  output logic               tos,
  output logic               stack_push,
  output logic               stack_pop,
  output logic               ld_B,
  output logic [2:0]         alu_op,
  output logic               halted,
  output logic [1:0]         err_code,
  output logic [DEPTH_W-1:0] depth
);
  state_t state, state_n;
  err_t err_q, err_n;
  logic [3:0] op;
  logic under, over, illegal;
  logic [DEPTH_W-1:0] depth_q;
  logic unused_operand;
  assign op = inst[INST_W-1 -: 4];
  assign unused_operand = ^inst[INST_W-5:0];
  assign illegal = op inside {4'hC, 4'hD, 4'hE};
  stack_depth_tracker #(.STACK_DEPTH(STACK_DEPTH), .DEPTH_W(DEPTH_W)) u_depth (
    .clk(clk), .rst(rst), .push(stack_push), .pop(stack_pop), .need(need_of(op)),
    .grow(op == OP_PUSH || op == OP_DUP), .depth(depth_q), .under(under), .over(over)
  );
  always_comb begin
    state_n = state;
    err_n = err_q;
    case (state)
      S_FETCH:   state_n = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:
        if (under || over || illegal) begin
          state_n = S_ERROR;
          err_n = under ? ERR_UNDER : over ? ERR_OVER : ERR_ILLEGAL;
        end else
          case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR: state_n = S_ALU_1;
            OP_NOT:          state_n = S_ALU_2;
            OP_PUSH:         state_n = S_PUSH_RD;
            OP_POP:          state_n = S_POP_1;
            OP_JMP:          state_n = S_JMP;
            OP_JZ, OP_JNZ:   state_n = S_JZ_1;
            OP_DUP:          state_n = S_DUP_1;
            OP_HALT:         state_n = S_HALT;
            default:         state_n = S_FETCH;
          endcase
      S_ALU_1:   state_n = S_ALU_2;
      S_ALU_2:   state_n = S_ALU_3;
      S_PUSH_RD: state_n = mem_ready ? S_PUSH_WR : S_PUSH_RD;
      S_POP_1:   state_n = S_POP_WR;
      S_POP_WR:  state_n = mem_ready ? S_FETCH : S_POP_WR;
      S_JZ_1:    state_n = ((op == OP_JZ) == zero) ? S_BR_TAKE : S_FETCH;
      S_DUP_1:   state_n = S_DUP_2;
      S_DUP_2:   state_n = S_DUP_3;
      S_ALU_3, S_PUSH_WR, S_JMP, S_BR_TAKE, S_DUP_3: state_n = S_FETCH;
      default:   state_n = state;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= S_FETCH;
      err_q <= ERR_NONE;
    end else begin
      state <= state_n;
      err_q <= err_n;
    end
  // Outputs are forced low for the whole reset cycle, not just after the edge.
  always_comb begin
    {mem_req, mem_write, mem_adr_src, ld_ir, ld_pc, pc_src, tos, stack_push, stack_pop, ld_B} = '0;
    stack_src = SRC_MEM;
    alu_op = ALU_ADD;
    if (!rst)
      case (state)
        S_FETCH: begin
          {mem_req, mem_adr_src} = '1;
          ld_ir = mem_ready;
          ld_pc = mem_ready;
        end
        S_ALU_1, S_DUP_1: {tos, stack_pop, ld_B} = '1;
        S_ALU_2: begin
          {tos, stack_pop} = '1;
          alu_op = alu_of(op);
        end
        S_ALU_3: begin
          stack_push = 1'b1;
          stack_src = SRC_ALU;
        end
        S_PUSH_RD: mem_req = 1'b1;
        S_PUSH_WR: stack_push = 1'b1;
        S_POP_1: {tos, stack_pop} = '1;
        S_POP_WR: {mem_req, mem_write} = '1;
        S_JMP, S_BR_TAKE: {ld_pc, pc_src} = '1;
        S_JZ_1: tos = 1'b1;
        S_DUP_2, S_DUP_3: begin
          stack_push = 1'b1;
          stack_src = SRC_B;
        end
        default: ;
      endcase
  end
  assign halted = !rst && (state == S_HALT || state == S_ERROR);
  assign err_code = rst ? ERR_NONE : err_q;
  assign depth = rst ? '0 : depth_q;
endmodule
